dsram_arb: RTL and testbench
============================

DSRAM_ARB -- requirements
Module: dsram_arb

Interface
REQ-001 Parameter P0_FIXED_PRIO, default 0: 1 = port 0 always wins contention; 0 = round-robin.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 flush  input  1  pipeline clear (exception/eret from WB); affects port 0 only.
REQ-005 pN_req  input  1  port N (N=0 MEM stage, N=1 secondary master) access request.
REQ-006 pN_we  input  4  byte write enables; 4'b0000 = read.
REQ-007 pN_addr  input  32  physical byte address.
REQ-008 pN_wdata  input  32  write data.
REQ-009 pN_gnt  output  1  access accepted this cycle (combinational).
REQ-010 pN_rvalid  output  1  read data valid.
REQ-011 pN_rdata  output  32  read data.
REQ-012 pN_rready  input  1  requester consumes read data this cycle.
REQ-013 data_sram_en  output  1, data_sram_wen  output  4, data_sram_addr  output  32, data_sram_wdata  output  32: SRAM command, driven from granted port.
REQ-014 data_sram_rdata  input  32  SRAM read data, valid one cycle after a read command.

Function
REQ-015 Port N SHALL be eligible iff pN_req, its skid register empty, and not (pN_rvalid and !pN_rready); port 0 additionally requires !flush.
REQ-016 At most one pN_gnt SHALL assert per cycle; a lone eligible port is granted.
REQ-017 Both eligible: P0_FIXED_PRIO=1 grants port 0; otherwise the port not granted most recently wins.
REQ-018 Last-granted pointer SHALL update only on a cycle with a grant.
REQ-019 data_sram_en = OR of grants; wen/addr/wdata = granted port's fields; with no grant data_sram_en=0, wen=0.
REQ-020 data_sram_wen SHALL be forced to 0 when the grant goes to port 0 and flush is high (unreachable via REQ-015; kept as guard).
REQ-021 Writes SHALL produce no response.
REQ-022 Read granted in cycle t: pN_rvalid=1 in t+1 with pN_rdata=data_sram_rdata (latency exactly 1).
REQ-023 If pN_rvalid and !pN_rready in t+1, data SHALL be captured into port N skid register; pN_rvalid stays 1 with skid data until the cycle pN_rready=1, skid then clears.
REQ-024 Consumption and new grant on same port in same cycle SHALL be allowed (back-to-back reads at 1/cycle with rready held high).
REQ-025 flush high: port 0 in-flight read response and skid SHALL be discarded that cycle; p0_rvalid=0 in the flush cycle and the next.
REQ-026 flush SHALL NOT alter port 1 grants, responses, skid, or the pointer except via REQ-018.
REQ-027 pN_rdata SHALL be 0 whenever pN_rvalid=0.

Reset
REQ-028 rst in a cycle: next cycle all gnt/rvalid=0, rdata=0, skids empty, outstanding-read flags cleared, pointer = port 1 last-granted (port 0 wins first tie).
REQ-029 Reset mid-transaction SHALL drop pending responses without emitting them; SRAM outputs during the rst cycle follow REQ-019 from inputs, requesters hold req low under reset.

Structure
REQ-030 Port index constants, width constants (32 address/data, 4 byte enables) SHALL reside in the shared defines header.
REQ-031 One sub-module dsram_arb_resp, instantiated per port: outstanding flag, skid register, rvalid/rdata mux, flush discard.

Verification
REQ-032 Only p0 read addr 0x100, rdata next cycle 0xDEADBEEF, rready=1 -> p0_gnt t0, p0_rvalid t1 with 0xDEADBEEF, then idle.
REQ-033 Both req continuous, reads, rready=1, P0_FIXED_PRIO=0 -> grants alternate p0,p1,p0,p1 starting p0 after reset; each rvalid one cycle after its grant.
REQ-034 p1 read granted t0, p1_rready=0 t1..t3, 1 at t4, SRAM returns 0x12345678 at t1 -> p1_rvalid t1..t4 holding 0x12345678; p1 not granted t1..t4 despite req; p0 granted meanwhile.
REQ-035 p0 read granted t0, flush=1 t1 -> p0_rvalid=0 t1,t2; p0_gnt=0 in t1; p1 write granted in t1 with data_sram_wen=4'b1111.
REQ-036 P0_FIXED_PRIO=1, both req for 4 cycles -> p0_gnt all 4 cycles, p1_gnt never.
REQ-037 rst=1 while p0 skid holds data -> next cycle p0_rvalid=0, skid empty; first subsequent tie goes to port 0.

Source files
------------

// File: rtl/dsram_arb_pkg.sv
// Shared widths, port indices and the read-response state type for the
// two-port data SRAM arbiter.
package dsram_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // Encoding of the last-granted pointer.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,  // no read response owed to this port
        RESP_LIVE = 2'd1,  // SRAM read data is on data_sram_rdata this cycle
        RESP_SKID = 2'd2   // response parked in the skid register
    } resp_state_e;

endpackage

// File: rtl/dsram_arb_resp.sv
// Per-port read-response tracker: outstanding flag, one-entry skid register,
// rvalid/rdata output mux and flush discard.
module dsram_arb_resp
    import dsram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              rd_issue,
    input  logic              rready,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output resp_state_e       state
);

    resp_state_e       state_q;
    resp_state_e       state_d;
    logic [DATA_W-1:0] skid_q;

    // Handshake: a response transfers in any cycle where rvalid && rready;
    // while rvalid && !rready the data and rvalid are held stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_q <= '0;
        end else if (state_q == RESP_LIVE && !rready && !flush) begin
            skid_q <= sram_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = RESP_IDLE;
        end else begin
            case (state_q)
                RESP_IDLE: if (rd_issue) state_d = RESP_LIVE;
                RESP_LIVE: begin
                    if (!rready)       state_d = RESP_SKID;
                    else if (rd_issue) state_d = RESP_LIVE;
                    else               state_d = RESP_IDLE;
                end
                RESP_SKID: if (rready) state_d = RESP_IDLE;
                default:   state_d = RESP_IDLE;
            endcase
        end
    end

    always_comb begin
        rvalid = 1'b0;
        rdata  = '0;
        if (!flush && state_q != RESP_IDLE) begin
            rvalid = 1'b1;
            rdata  = (state_q == RESP_SKID) ? skid_q : sram_rdata;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/dsram_arb.sv
// Two-port data SRAM arbiter: MEM stage (port 0) and a secondary master
// (port 1) share one single-cycle SRAM, with round-robin or fixed priority.
module dsram_arb
    import dsram_arb_pkg::*;
#(
    parameter int P0_FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              p0_req,
    input  logic [BE_W-1:0]   p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p0_rready,

    input  logic              p1_req,
    input  logic [BE_W-1:0]   p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    input  logic              p1_rready,

    output logic              data_sram_en,
    output logic [BE_W-1:0]   data_sram_wen,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic [DATA_W-1:0] data_sram_rdata
);

    resp_state_e p0_state;
    resp_state_e p1_state;
    logic        p0_elig;
    logic        p1_elig;
    logic        last_q;

    // A port may not issue while it still owes a response it cannot retire.
    always_comb begin
        p0_elig = p0_req && !flush && (p0_state != RESP_SKID) && !(p0_rvalid && !p0_rready);
        p1_elig = p1_req && (p1_state != RESP_SKID) && !(p1_rvalid && !p1_rready);
    end

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (p0_elig && p1_elig) begin
            if (P0_FIXED_PRIO != 0 || last_q == PORT1) p0_gnt = 1'b1;
            else                                       p1_gnt = 1'b1;
        end else begin
            p0_gnt = p0_elig;
            p1_gnt = p1_elig;
        end
    end

    // Reset points at port 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PORT1;
        end else if (p0_gnt || p1_gnt) begin
            last_q <= p1_gnt ? PORT1 : PORT0;
        end
    end

    always_comb begin
        data_sram_en    = 1'b0;
        data_sram_wen   = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        if (p0_gnt) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = flush ? '0 : p0_we;
            data_sram_addr  = p0_addr;
            data_sram_wdata = p0_wdata;
        end else if (p1_gnt) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = p1_we;
            data_sram_addr  = p1_addr;
            data_sram_wdata = p1_wdata;
        end
    end

    dsram_arb_resp u_p0_resp (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .rd_issue   (p0_gnt && p0_we == '0),
        .rready     (p0_rready),
        .sram_rdata (data_sram_rdata),
        .rvalid     (p0_rvalid),
        .rdata      (p0_rdata),
        .state      (p0_state)
    );

    // Flush is an MEM-stage event; the secondary master never sees it.
    dsram_arb_resp u_p1_resp (
        .clk        (clk),
        .rst        (rst),
        .flush      (1'b0),
        .rd_issue   (p1_gnt && p1_we == '0),
        .rready     (p1_rready),
        .sram_rdata (data_sram_rdata),
        .rvalid     (p1_rvalid),
        .rdata      (p1_rdata),
        .state      (p1_state)
    );

endmodule

// File: tb/tb_dsram_arb.sv
// Directed bench for dsram_arb: round-robin instance plus a fixed-priority
// instance sharing the same stimulus.
module tb_dsram_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        p0_req, p1_req;
    logic [3:0]  p0_we, p1_we;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic        p0_rready, p1_rready;
    logic [31:0] data_sram_rdata;

    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata;

    logic        f_p0_gnt, f_p1_gnt, f_p0_rvalid, f_p1_rvalid;
    logic [31:0] f_p0_rdata, f_p1_rdata;
    logic        f_sram_en;
    logic [3:0]  f_sram_wen;
    logic [31:0] f_sram_addr, f_sram_wdata;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    dsram_arb #(.P0_FIXED_PRIO(0)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_rready(p0_rready),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_rready(p1_rready),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata)
    );

    dsram_arb #(.P0_FIXED_PRIO(1)) u_fix (
        .clk(clk), .rst(rst), .flush(flush),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(f_p0_gnt), .p0_rvalid(f_p0_rvalid), .p0_rdata(f_p0_rdata), .p0_rready(p0_rready),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(f_p1_gnt), .p1_rvalid(f_p1_rvalid), .p1_rdata(f_p1_rdata), .p1_rready(p1_rready),
        .data_sram_en(f_sram_en), .data_sram_wen(f_sram_wen),
        .data_sram_addr(f_sram_addr), .data_sram_wdata(f_sram_wdata),
        .data_sram_rdata(data_sram_rdata)
    );

    task automatic idle_inputs();
        flush = 1'b0;
        p0_req = 1'b0; p0_we = 4'h0; p0_addr = '0; p0_wdata = '0; p0_rready = 1'b1;
        p1_req = 1'b0; p1_we = 4'h0; p1_addr = '0; p1_wdata = '0; p1_rready = 1'b1;
        data_sram_rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        vec++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, data_sram_en} !== 5'b0) begin
            errs++;
            $display("FAIL reset_flags got %b exp 00000", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, data_sram_en});
        end
        vec++;
        if ({p0_rdata, p1_rdata} !== 64'h0 || data_sram_wen !== 4'h0) begin
            errs++;
            $display("FAIL reset_data got %h %h wen %h exp 0", p0_rdata, p1_rdata, data_sram_wen);
        end
        vec++;
        if ({f_p0_gnt, f_p1_gnt, f_p0_rvalid, f_p1_rvalid, f_sram_en} !== 5'b0) begin
            errs++;
            $display("FAIL reset_fix_flags got %b exp 00000", {f_p0_gnt, f_p1_gnt, f_p0_rvalid, f_p1_rvalid, f_sram_en});
        end
        next_cycle();
    endtask

    task automatic test_single_read();
        idle_inputs();
        p0_req = 1'b1; p0_addr = 32'h0000_0100;
        @(negedge clk);
        vec++;
        if ({p0_gnt, p1_gnt, data_sram_en} !== 3'b101 || data_sram_wen !== 4'h0) begin
            errs++;
            $display("FAIL single_t0_gnt got gnt %b%b en %b wen %h exp 1 0 1 0", p0_gnt, p1_gnt, data_sram_en, data_sram_wen);
        end
        vec++;
        if (data_sram_addr !== 32'h0000_0100) begin
            errs++;
            $display("FAIL single_t0_addr got %h exp 00000100", data_sram_addr);
        end
        next_cycle();
        p0_req = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        vec++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEAD_BEEF || p0_gnt !== 1'b0) begin
            errs++;
            $display("FAIL single_t1_resp got v %b d %h g %b exp 1 deadbeef 0", p0_rvalid, p0_rdata, p0_gnt);
        end
        next_cycle();
        data_sram_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        vec++;
        if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) begin
            errs++;
            $display("FAIL single_t2_idle got v %b d %h exp 0 0", p0_rvalid, p0_rdata);
        end
        next_cycle();
    endtask

    task automatic test_alternate();
        logic        eg0, ev0, ev1;
        logic [31:0] ea, ed;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            p0_req = (i < 4); p1_req = (i < 4);
            p0_addr = 32'h400 + 32'(i * 4);
            p1_addr = 32'h800 + 32'(i * 4);
            data_sram_rdata = 32'hA000_0000 + 32'(i);
            eg0 = (i % 2 == 0);
            ev0 = (i > 0) && ((i - 1) % 2 == 0);
            ev1 = (i > 0) && ((i - 1) % 2 == 1);
            ea  = eg0 ? p0_addr : p1_addr;
            ed  = 32'hA000_0000 + 32'(i);
            @(negedge clk);
            if (i < 4) begin
                vec++;
                if (p0_gnt !== eg0 || p1_gnt !== !eg0 || data_sram_addr !== ea) begin
                    errs++;
                    $display("FAIL rr_gnt[%0d] got %b%b addr %h exp %b%b %h", i, p0_gnt, p1_gnt, data_sram_addr, eg0, !eg0, ea);
                end
                vec++;
                if (f_p0_gnt !== 1'b1 || f_p1_gnt !== 1'b0) begin
                    errs++;
                    $display("FAIL fix_gnt[%0d] got %b%b exp 10", i, f_p0_gnt, f_p1_gnt);
                end
            end
            vec++;
            if (p0_rvalid !== ev0 || p1_rvalid !== ev1) begin
                errs++;
                $display("FAIL rr_rvalid[%0d] got %b%b exp %b%b", i, p0_rvalid, p1_rvalid, ev0, ev1);
            end
            vec++;
            if (p0_rdata !== (ev0 ? ed : 32'h0) || p1_rdata !== (ev1 ? ed : 32'h0)) begin
                errs++;
                $display("FAIL rr_rdata[%0d] got %h %h exp data %h on valid port", i, p0_rdata, p1_rdata, ed);
            end
            next_cycle();
        end
    endtask

    task automatic test_skid();
        idle_inputs();
        p1_req = 1'b1; p1_addr = 32'h200;
        @(negedge clk);
        vec++;
        if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin
            errs++;
            $display("FAIL skid_t0_gnt got %b%b exp 01", p0_gnt, p1_gnt);
        end
        next_cycle();
        for (int t = 1; t <= 4; t++) begin
            p1_rready = (t == 4);
            p0_req = 1'b1; p0_addr = 32'h300 + 32'(t);
            data_sram_rdata = (t == 1) ? 32'h1234_5678 : 32'hAAAA_5550 + 32'(t);
            @(negedge clk);
            vec++;
            if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h1234_5678) begin
                errs++;
                $display("FAIL skid_hold[%0d] got v %b d %h exp 1 12345678", t, p1_rvalid, p1_rdata);
            end
            vec++;
            if (p1_gnt !== 1'b0 || p0_gnt !== 1'b1) begin
                errs++;
                $display("FAIL skid_gnt[%0d] got %b%b exp 10", t, p0_gnt, p1_gnt);
            end
            next_cycle();
        end
        p1_rready = 1'b1;
        data_sram_rdata = 32'h0;
        @(negedge clk);
        vec++;
        if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || p1_rvalid !== 1'b0) begin
            errs++;
            $display("FAIL skid_t5_rr got gnt %b%b v1 %b exp 01 0", p0_gnt, p1_gnt, p1_rvalid);
        end
        next_cycle();
        p0_req = 1'b0; p1_req = 1'b0;
        data_sram_rdata = 32'h5A5A_0001;
        @(negedge clk);
        vec++;
        if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h5A5A_0001 || p0_rvalid !== 1'b0) begin
            errs++;
            $display("FAIL skid_t6_resp got v1 %b d1 %h v0 %b exp 1 5a5a0001 0", p1_rvalid, p1_rdata, p0_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_flush();
        idle_inputs();
        p0_req = 1'b1; p0_addr = 32'h100;
        @(negedge clk);
        vec++;
        if (p0_gnt !== 1'b1) begin
            errs++;
            $display("FAIL flush_t0_gnt got %b exp 1", p0_gnt);
        end
        next_cycle();
        flush = 1'b1;
        p1_req = 1'b1; p1_we = 4'hF; p1_addr = 32'h300; p1_wdata = 32'hCAFE_F00D;
        data_sram_rdata = 32'h1111_1111;
        @(negedge clk);
        vec++;
        if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0 || p0_gnt !== 1'b0) begin
            errs++;
            $display("FAIL flush_t1_p0 got v %b d %h g %b exp 0 0 0", p0_rvalid, p0_rdata, p0_gnt);
        end
        vec++;
        if (p1_gnt !== 1'b1 || data_sram_wen !== 4'hF || data_sram_wdata !== 32'hCAFE_F00D) begin
            errs++;
            $display("FAIL flush_t1_p1w got g %b wen %h wd %h exp 1 f cafef00d", p1_gnt, data_sram_wen, data_sram_wdata);
        end
        next_cycle();
        idle_inputs();
        data_sram_rdata = 32'h2222_2222;
        @(negedge clk);
        vec++;
        if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
            errs++;
            $display("FAIL flush_t2_quiet got %b%b exp 00", p0_rvalid, p1_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_reset_skid();
        idle_inputs();
        p0_req = 1'b1; p0_addr = 32'h500;
        @(negedge clk);
        vec++;
        if (p0_gnt !== 1'b1) begin
            errs++;
            $display("FAIL rskid_t0_gnt got %b exp 1", p0_gnt);
        end
        next_cycle();
        p0_req = 1'b0; p0_rready = 1'b0; data_sram_rdata = 32'h55AA_55AA;
        next_cycle();
        rst = 1'b1; data_sram_rdata = 32'h0;
        @(negedge clk);
        vec++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h55AA_55AA) begin
            errs++;
            $display("FAIL rskid_t2_held got v %b d %h exp 1 55aa55aa", p0_rvalid, p0_rdata);
        end
        next_cycle();
        rst = 1'b0;
        p0_rready = 1'b1;
        p0_req = 1'b1; p1_req = 1'b1; p0_addr = 32'h600; p1_addr = 32'h700;
        @(negedge clk);
        vec++;
        if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) begin
            errs++;
            $display("FAIL rskid_t3_drop got v %b d %h exp 0 0", p0_rvalid, p0_rdata);
        end
        vec++;
        if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
            errs++;
            $display("FAIL rskid_t3_tie got %b%b exp 10", p0_gnt, p1_gnt);
        end
        next_cycle();
        idle_inputs();
        data_sram_rdata = 32'h0000_0600;
        @(negedge clk);
        vec++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h0000_0600 || p1_rvalid !== 1'b0) begin
            errs++;
            $display("FAIL rskid_t4_resp got v0 %b d0 %h v1 %b exp 1 00000600 0", p0_rvalid, p0_rdata, p1_rvalid);
        end
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_alternate();
        test_skid();
        test_flush();
        test_reset_skid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
